// File: rtl/prog_loader_if.sv
// Loader-side bus bundle: host byte stream in, instruction memory write port and
// processor control out.
//   start      host -> loader  one-cycle load request
//   in_valid   host -> loader  byte available on in_data
//   in_data    host -> loader  stream byte
//   in_ready   loader -> host  loader takes a byte this cycle
//   mem_we     loader -> imem  write strobe, one cycle per word
//   mem_addr   loader -> imem  write address
//   mem_wdata  loader -> imem  write data {hi, lo}
//   cpu_hold   loader -> core  1 holds the processor in reset
//   done       loader -> host  load finished (level)
//   err        loader -> host  checksum mismatch on last load
interface prog_loader_if #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
);
    logic              start;
    logic              in_valid;
    logic [7:0]        in_data;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              cpu_hold;
    logic              done;
    logic              err;

    // Host / stream source side.
    modport master (
        output start, in_valid, in_data,
        input  in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );

    // Loader side.
    modport slave (
        input  start, in_valid, in_data,
        output in_ready, mem_we, mem_addr, mem_wdata, cpu_hold, done, err
    );
endinterface

// File: rtl/prog_loader.sv
// Byte-stream program loader. Accepts a frame of
//   count, {hi, lo} x count, xor-checksum
// over a valid/ready handshake and writes each 16-bit word to consecutive instruction
// memory addresses starting at 0. A count byte of 0 means 2**ADDR_W words. The processor
// is held in reset until a load finishes with a matching checksum.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous, active-high reset
//   bus    prog_loader_if.slave (stream input, memory write port, cpu_hold/done/err)
module prog_loader #(
    parameter int unsigned ADDR_W = 8,
    parameter int unsigned DATA_W = 16
) (
    input  logic         clk,
    input  logic         reset,
    prog_loader_if.slave bus
);

    typedef enum logic [2:0] {
        StIdle,
        StCount,
        StHi,
        StLo,
        StWrite,
        StCheck,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] remaining_q, remaining_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        hi_q, hi_d;
    logic [7:0]        chk_q, chk_d;
    logic              done_q, done_d;
    logic              err_q, err_d;
    logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;

    logic in_ready;
    logic hs;

    // in_ready is a pure decode of the state register.
    always_comb begin
        in_ready = (state_q == StCount) || (state_q == StHi) ||
                   (state_q == StLo) || (state_q == StCheck);
    end

    assign hs = bus.in_valid & in_ready;

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        addr_d      = addr_q;
        hi_d        = hi_q;
        chk_d       = chk_q;
        done_d      = done_q;
        err_d       = err_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        unique case (state_q)
            StIdle, StDone: begin
                if (bus.start) begin
                    state_d = StCount;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    chk_d   = 8'h00;
                end
            end
            StCount: begin
                if (hs) begin
                    // 0 naturally means 2**ADDR_W: the down-counter wraps before reaching 1.
                    remaining_d = ADDR_W'(bus.in_data);
                    addr_d      = '0;
                    chk_d       = chk_q ^ bus.in_data;
                    state_d     = StHi;
                end
            end
            StHi: begin
                if (hs) begin
                    hi_d    = bus.in_data;
                    chk_d   = chk_q ^ bus.in_data;
                    state_d = StLo;
                end
            end
            StLo: begin
                if (hs) begin
                    chk_d = chk_q ^ bus.in_data;
                    // Load the output registers here so they are valid throughout WRITE
                    // and keep the last written word afterwards.
                    mem_addr_d  = addr_q;
                    mem_wdata_d = DATA_W'({hi_q, bus.in_data});
                    state_d     = StWrite;
                end
            end
            StWrite: begin
                addr_d      = addr_q + ADDR_W'(1);
                remaining_d = remaining_q - ADDR_W'(1);
                state_d     = (remaining_q == ADDR_W'(1)) ? StCheck : StHi;
            end
            StCheck: begin
                if (hs) begin
                    err_d   = (bus.in_data != chk_q);
                    done_d  = 1'b1;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= StIdle;
            remaining_q <= '0;
            addr_q      <= '0;
            hi_q        <= 8'h00;
            chk_q       <= 8'h00;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            remaining_q <= remaining_d;
            addr_q      <= addr_d;
            hi_q        <= hi_d;
            chk_q       <= chk_d;
            done_q      <= done_d;
            err_q       <= err_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
        end
    end

    assign bus.in_ready  = in_ready;
    assign bus.mem_we    = (state_q == StWrite);
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.done      = done_q;
    assign bus.err       = err_q;
    // Released only in DONE after a good checksum.
    assign bus.cpu_hold  = !((state_q == StDone) && !err_q);

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;

    logic clk;
    logic reset;

    prog_loader_if #(.ADDR_W(8), .DATA_W(16)) bus ();

    prog_loader #(.ADDR_W(8), .DATA_W(16)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [7:0]  wr_addr[$];
    logic [15:0] wr_data[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic timeout_fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s: timed out waiting for DUT", name);
    endtask

    // Write monitor: records every write and requires in_ready low in WRITE.
    always @(negedge clk) begin
        if (bus.mem_we === 1'b1) begin
            wr_addr.push_back(bus.mem_addr);
            wr_data.push_back(bus.mem_wdata);
            check("in_ready_during_write", {31'd0, bus.in_ready}, 32'd0);
        end
    end

    // All drive tasks begin and end 1 time unit after a rising edge.
    task automatic send_byte(input logic [7:0] b, input int bubbles);
        bit ok;
        repeat (bubbles) begin
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        ok = 1'b0;
        for (int t = 0; t < 50 && !ok; t++) begin
            @(negedge clk);
            if (bus.in_ready === 1'b1) ok = 1'b1;
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        if (!ok) timeout_fail($sformatf("send_byte_%h", b));
    endtask

    task automatic do_start(input string tag);
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
        // Now in COUNT.
        check({tag, "_count_ready"}, {31'd0, bus.in_ready}, 32'd1);
        check({tag, "_count_done"},  {31'd0, bus.done},     32'd0);
        check({tag, "_count_hold"},  {31'd0, bus.cpu_hold}, 32'd1);
    endtask

    task automatic pulse_start();
        bus.start = 1'b1;
        @(posedge clk);
        #1;
        bus.start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit ok;
        ok = 1'b0;
        for (int t = 0; t < 100 && !ok; t++) begin
            @(negedge clk);
            if (bus.done === 1'b1) ok = 1'b1;
        end
        if (!ok) timeout_fail({tag, "_done_wait"});
        @(posedge clk);
        #1;
    endtask

    typedef struct packed {
        logic [1:0]  n;       // words actually sent (1..3)
        logic [7:0]  count;
        logic [15:0] w0;
        logic [15:0] w1;
        logic [15:0] w2;
        logic [7:0]  chk;
        logic        exp_err;
        logic        bubbles;
    } vec_t;

    function automatic vec_t mk(input logic [1:0] n, input logic [7:0] count,
                                input logic [15:0] w0, input logic [15:0] w1,
                                input logic [15:0] w2, input logic [7:0] chk,
                                input logic exp_err, input logic bubbles);
        vec_t v;
        v.n = n; v.count = count; v.w0 = w0; v.w1 = w1; v.w2 = w2;
        v.chk = chk; v.exp_err = exp_err; v.bubbles = bubbles;
        return v;
    endfunction

    task automatic check_writes(input string tag, input logic [15:0] exp_w[$]);
        check({tag, "_nwrites"}, wr_data.size(), exp_w.size());
        for (int i = 0; i < exp_w.size() && i < wr_data.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), {24'd0, wr_addr[i]}, i);
            check($sformatf("%s_data%0d", tag, i), {16'd0, wr_data[i]}, {16'd0, exp_w[i]});
        end
    endtask

    vec_t vecs[5];

    initial begin
        logic [15:0] exp_w[$];
        logic [15:0] w;
        logic [7:0]  chk;
        string       tag;

        // 02^12^34^AB^CD = 42; 01^A5^5A = FE; 03^00^01^80^00^FF^FF = 82.
        vecs[0] = mk(2'd2, 8'h02, 16'h1234, 16'hABCD, 16'h0000, 8'h42, 1'b0, 1'b0);
        vecs[1] = mk(2'd2, 8'h02, 16'h1234, 16'hABCD, 16'h0000, 8'h41, 1'b1, 1'b0);
        vecs[2] = mk(2'd2, 8'h02, 16'h1234, 16'hABCD, 16'h0000, 8'h42, 1'b0, 1'b1);
        vecs[3] = mk(2'd1, 8'h01, 16'hA55A, 16'h0000, 16'h0000, 8'hFE, 1'b0, 1'b1);
        vecs[4] = mk(2'd3, 8'h03, 16'h0001, 16'h8000, 16'hFFFF, 8'h82, 1'b0, 1'b0);

        bus.start    = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = 8'h00;
        reset        = 1'b1;
        #2;
        check("rst_in_ready",  {31'd0, bus.in_ready}, 32'd0);
        check("rst_mem_we",    {31'd0, bus.mem_we},   32'd0);
        check("rst_mem_addr",  {24'd0, bus.mem_addr}, 32'd0);
        check("rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
        check("rst_cpu_hold",  {31'd0, bus.cpu_hold}, 32'd1);
        check("rst_done",      {31'd0, bus.done},     32'd0);
        check("rst_err",       {31'd0, bus.err},      32'd0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("idle_in_ready", {31'd0, bus.in_ready}, 32'd0);

        // Table-driven frames; rows after the first also exercise start from DONE.
        for (int r = 0; r < 5; r++) begin
            tag = $sformatf("vec%0d", r);
            wr_addr.delete();
            wr_data.delete();
            exp_w.delete();
            do_start(tag);
            send_byte(vecs[r].count, vecs[r].bubbles ? $urandom_range(0, 5) : 0);
            for (int i = 0; i < vecs[r].n; i++) begin
                w = (i == 0) ? vecs[r].w0 : (i == 1) ? vecs[r].w1 : vecs[r].w2;
                exp_w.push_back(w);
                send_byte(w[15:8], vecs[r].bubbles ? $urandom_range(0, 5) : 0);
                send_byte(w[7:0],  vecs[r].bubbles ? $urandom_range(0, 5) : 0);
            end
            send_byte(vecs[r].chk, vecs[r].bubbles ? $urandom_range(0, 5) : 0);
            wait_done(tag);
            check_writes(tag, exp_w);
            check({tag, "_done"},     {31'd0, bus.done},     32'd1);
            check({tag, "_err"},      {31'd0, bus.err},      {31'd0, vecs[r].exp_err});
            check({tag, "_cpu_hold"}, {31'd0, bus.cpu_hold}, {31'd0, vecs[r].exp_err});
            check({tag, "_ready"},    {31'd0, bus.in_ready}, 32'd0);
        end

        // Full 256-word load via count 0; word i = {i, ~i}.
        wr_addr.delete();
        wr_data.delete();
        exp_w.delete();
        do_start("full");
        chk = 8'h00;
        send_byte(8'h00, 0);
        for (int i = 0; i < 256; i++) begin
            w = {8'(i), ~8'(i)};
            exp_w.push_back(w);
            chk = chk ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        send_byte(chk, 0);
        wait_done("full");
        check_writes("full", exp_w);
        check("full_done",     {31'd0, bus.done},     32'd1);
        check("full_err",      {31'd0, bus.err},      32'd0);
        check("full_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);

        // Reset after 3 of 5 words written.
        wr_addr.delete();
        wr_data.delete();
        do_start("mid");
        send_byte(8'h05, 0);
        for (int i = 0; i < 3; i++) begin
            send_byte(8'h10 + 8'(i), 0);
            send_byte(8'h20 + 8'(i), 0);
        end
        @(posedge clk);
        #1;
        // Now in HI for word 3, with in_ready high and a non-zero address held.
        check("mid_pre_ready", {31'd0, bus.in_ready}, 32'd1);
        check("mid_nwrites", wr_data.size(), 3);
        reset = 1'b1;
        #1;
        check("mid_rst_in_ready",  {31'd0, bus.in_ready},  32'd0);
        check("mid_rst_mem_addr",  {24'd0, bus.mem_addr},  32'd0);
        check("mid_rst_mem_wdata", {16'd0, bus.mem_wdata}, 32'd0);
        check("mid_rst_cpu_hold",  {31'd0, bus.cpu_hold},  32'd1);
        check("mid_rst_done",      {31'd0, bus.done},      32'd0);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("mid_idle_ready", {31'd0, bus.in_ready}, 32'd0);
        wr_addr.delete();
        wr_data.delete();
        exp_w.delete();
        do_start("reload");
        chk = 8'h05;
        send_byte(8'h05, 0);
        for (int i = 0; i < 5; i++) begin
            w = {8'h30 + 8'(i), 8'hC0 + 8'(i)};
            exp_w.push_back(w);
            chk = chk ^ w[15:8] ^ w[7:0];
            send_byte(w[15:8], 0);
            send_byte(w[7:0], 0);
        end
        send_byte(chk, 0);
        wait_done("reload");
        check_writes("reload", exp_w);
        check("reload_done", {31'd0, bus.done}, 32'd1);
        check("reload_err",  {31'd0, bus.err},  32'd0);

        // start pulses in HI and LO must be ignored. 01^12^34 = 27.
        wr_addr.delete();
        wr_data.delete();
        exp_w.delete();
        exp_w.push_back(16'h1234);
        do_start("ign");
        send_byte(8'h01, 0);
        pulse_start();
        check("ign_in_hi_ready", {31'd0, bus.in_ready}, 32'd1);
        send_byte(8'h12, 0);
        pulse_start();
        send_byte(8'h34, 0);
        send_byte(8'h27, 0);
        wait_done("ign");
        check_writes("ign", exp_w);
        check("ign_done",     {31'd0, bus.done},     32'd1);
        check("ign_err",      {31'd0, bus.err},      32'd0);
        check("ign_cpu_hold", {31'd0, bus.cpu_hold}, 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
